// File: rtl/rr_arb_4.sv
// rr_arb_4 -- four-requester round-robin arbiter driving a 2-to-4 decoder.
// A grant is held until the owner signals done or drops its request; the
// rotating pointer moves to the requester after the last owner on release.
// Optional feature macro: RR_ARB_TIMEOUT_EN adds a forced release after
// MAX_HOLD grant cycles. With the macro undefined a grant is held indefinitely.
module rr_arb_4 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       enable,
  output logic [3:0] grant_n,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] sel_q;
  logic       enable_q;
  logic [3:0] grant_n_q;
  logic       busy_q;
  logic [1:0] pick_s;
  logic       release_s;

  // Reject an out-of-range hold limit while elaborating.
  if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("rr_arb_4: MAX_HOLD must be in 1..255");
  end

  // First set request found scanning upward from the pointer, modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_q;

  // Release when the owner finishes, withdraws, or has used its full hold time.
  always_comb begin
    release_s = done | ~req[sel_q] | (hold_q == 8'(MAX_HOLD - 1));
  end
`else
  // Release only when the owner finishes or withdraws its request.
  always_comb begin
    release_s = done | ~req[sel_q];
  end
`endif

  // Winner of a fresh arbitration round.
  always_comb begin
    pick_s = rr_pick(req, ptr_q);
  end

  // Arbiter FSM with registered decoder outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      enable_q  <= 1'b1;
      grant_n_q <= 4'b1111;
      busy_q    <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req != 4'b0000) begin
            state_q   <= ST_GRANT;
            sel_q     <= pick_s;
            enable_q  <= 1'b0;
            grant_n_q <= ~(4'b0001 << pick_s);
            busy_q    <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            state_q   <= ST_IDLE;
            enable_q  <= 1'b1;
            grant_n_q <= 4'b1111;
            busy_q    <= 1'b0;
            ptr_q     <= sel_q + 2'd1;
          end else begin
            state_q <= ST_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            hold_q  <= hold_q + 8'd1;
`endif
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          enable_q  <= 1'b1;
          grant_n_q <= 4'b1111;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sel     = sel_q;
  assign enable  = enable_q;
  assign grant_n = grant_n_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rr_arb_4.sv
// Testbench for rr_arb_4: directed stimulus, a per-cycle reference model and
// hand-computed expectations at the interesting points.
module tb_rr_arb_4;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
  localparam bit TB_TO       = 1'b1;
`else
  localparam int TB_MAX_HOLD = 15;
  localparam bit TB_TO       = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic       enable;
  logic [3:0] grant_n;
  logic       busy;

  int checks = 0;
  int failures = 0;

  rr_arb_4 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .enable(enable), .grant_n(grant_n), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: "who owns the resource" as plain integers.
  int m_grant = 0;
  int m_ptr = 0;
  int m_sel = 0;
  int m_cycles = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_grant = 0; m_ptr = 0; m_sel = 0; m_cycles = 0;
    end else if (m_grant == 0) begin
      if (req != 4'b0000) begin
        int found;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (found == 0 && req[(m_ptr + k) % 4]) begin
            m_sel = (m_ptr + k) % 4;
            found = 1;
          end
        end
        m_grant = 1;
        m_cycles = 0;
      end
    end else begin
      m_cycles = m_cycles + 1;
      if (done || !req[m_sel] || (TB_TO && m_cycles >= TB_MAX_HOLD)) begin
        m_grant = 0;
        m_ptr = (m_sel + 1) % 4;
      end
    end
  end

  // Compare DUT outputs to the model and the grant invariant every cycle.
  always @(posedge clk) begin
    logic [3:0] e_gn;
    #1;
    e_gn = (m_grant != 0) ? ~(4'b0001 << m_sel) : 4'b1111;
    chk("model_sel", int'(sel), m_sel);
    chk("model_enable", int'(enable), (m_grant != 0) ? 0 : 1);
    chk("model_grant_n", int'(grant_n), int'(e_gn));
    chk("model_busy", int'(busy), m_grant);
    chk("inv_onehot", ($countones(~grant_n) <= 1) ? 1 : 0, 1);
    chk("inv_enable", ((grant_n == 4'b1111) == enable) ? 1 : 0, 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] seq_gn  [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    int n;
    // Reset state.
    step(); step();
    chk("rst_enable", int'(enable), 1);
    chk("rst_grant_n", int'(grant_n), 15);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // Full rotation with all requesting, done pulsed each grant.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rot_sel", int'(sel), int'(seq_sel[i]));
      chk("rot_grant_n", int'(grant_n), int'(seq_gn[i]));
      done = 1'b1;
      step();
      chk("rot_idle_enable", int'(enable), 1);
      chk("rot_idle_sel_kept", int'(sel), int'(seq_sel[i]));
      done = 1'b0;
    end
    req = 4'b0000;
    rst_n = 1'b0; step(); rst_n = 1'b1;

    // Single requester 2, then wrap from pointer 3 to requester 0.
    req = 4'b0100;
    step();
    chk("r2_sel", int'(sel), 2);
    chk("r2_grant_n", int'(grant_n), 4'b1011);
    chk("r2_enable", int'(enable), 0);
    done = 1'b1; step(); done = 1'b0;
    req = 4'b0101;
    step();
    chk("wrap_sel", int'(sel), 0);
    chk("wrap_grant_n", int'(grant_n), 4'b1110);
    req = 4'b0000; step();
    chk("drop_release", int'(busy), 0);

    // Grant to 1 held against other requests until req[1] drops.
    req = 4'b0010; step();
    chk("hold_sel", int'(sel), 1);
    req = 4'b1011; step();
    chk("hold_gn_a", int'(grant_n), 4'b1101);
    step();
    chk("hold_gn_b", int'(grant_n), 4'b1101);
    req = 4'b1001; step();
    chk("hold_release", int'(enable), 1);
    step();
    chk("after_hold_sel", int'(sel), 3);
    chk("after_hold_gn", int'(grant_n), 4'b0111);
    req = 4'b0000; step();

    // Reset in the middle of a grant to requester 2.
    req = 4'b0100; step();
    chk("pre_rst_sel", int'(sel), 2);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_enable", int'(enable), 1);
    chk("midrst_grant_n", int'(grant_n), 15);
    chk("midrst_sel", int'(sel), 0);
    chk("midrst_busy", int'(busy), 0);
    req = 4'b1111; step();
    chk("postrst_sel", int'(sel), 0);
    req = 4'b0000; step();

    // done while idle is ignored.
    done = 1'b1; step();
    chk("idle_done_busy", int'(busy), 0);
    done = 1'b0;

    // done together with pending requests: release, then re-arbitrate.
    req = 4'b1111; step();
    chk("sim_sel_a", int'(sel), 1);
    done = 1'b1; step();
    chk("sim_release", int'(busy), 0);
    done = 1'b0; step();
    chk("sim_sel_b", int'(sel), 2);
    req = 4'b0000; step();

    // Long hold with done low: forced release only when timeout is built in.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 4'b0011; step();
    n = 1;
    while (busy && sel == 2'd0 && n < 110) begin
      step();
      if (busy && sel == 2'd0) n++;
    end
`ifdef RR_ARB_TIMEOUT_EN
    chk("to_hold_cycles", n, 4);
    chk("to_idle", int'(enable), 1);
    step();
    chk("to_next_sel", int'(sel), 1);
    chk("to_next_busy", int'(busy), 1);
`else
    chk("noto_hold_cycles", n, 110);
    chk("noto_still_busy", int'(busy), 1);
`endif
    req = 4'b0000; step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 15, maximum grant length in cycles when timeout is compiled in (1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: req  input  4  request per requester, active-high, level.
REQ-005 SHALL have port: done  input  1  current owner releases the resource, active-high, sampled only in GRANT.
REQ-006 SHALL have port: sel  output  2  index of current/last owner; drives the 2-to-4 decoder select.
REQ-007 SHALL have port: enable  output  1  decoder enable, active-low convention: 0 = grant active, 1 = all outputs inactive.
REQ-008 SHALL have port: grant_n  output  4  one-hot-low grant: bit sel = 0 when enable = 0; all 1 otherwise.
REQ-009 SHALL have port: busy  output  1  1 while FSM is in GRANT.

Function
REQ-010 SHALL implement FSM with states IDLE and GRANT; all outputs registered.
REQ-011 SHALL keep a 2-bit priority pointer ptr; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 IDLE, req != 0: next edge -> GRANT, sel = first set req in search order, enable = 0, grant_n[sel] = 0, busy = 1.
REQ-013 IDLE, req == 0: SHALL remain IDLE, outputs unchanged (enable = 1, grant_n = 4'b1111, busy = 0).
REQ-014 GRANT: SHALL hold sel, enable, grant_n stable regardless of other req changes.
REQ-015 GRANT, done = 1 or req[sel] = 0: next edge -> IDLE, enable = 1, grant_n = 4'b1111, busy = 0, ptr = sel + 1 mod 4 (3 wraps to 0).
REQ-016 sel SHALL retain last owner value in IDLE.
REQ-017 Minimum one IDLE cycle between consecutive grants; grant latency from req in IDLE = 1 cycle.
REQ-018 done asserted while in IDLE SHALL be ignored.
REQ-019 Simultaneous done and new requests in GRANT: release first; new arbitration on following IDLE cycle with updated ptr.
REQ-020 grant_n SHALL never have more than one 0 bit; grant_n == 4'b1111 iff enable == 1.

Reset
REQ-021 rst_n = 0 at a rising edge SHALL force: state IDLE, ptr = 0, sel = 2'b00, enable = 1, grant_n = 4'b1111, busy = 0, hold counter = 0.
REQ-022 Reset asserted during GRANT SHALL drop the grant on that edge, no ptr update from the aborted grant.
REQ-023 First grant after reset SHALL favour requester 0.

Configuration
REQ-024 Macro RR_ARB_TIMEOUT_EN SHALL select forced-release feature.
REQ-025 With RR_ARB_TIMEOUT_EN defined: 8-bit hold counter clears on entry to GRANT, increments each GRANT cycle; after MAX_HOLD GRANT cycles without release -> IDLE as in REQ-015 (ptr advances).
REQ-026 Without RR_ARB_TIMEOUT_EN: no counter logic; grant held indefinitely until done or req[sel] drops; MAX_HOLD unused.

Verification
REQ-027 Reset, then req = 4'b1111, done pulse each grant -> sel sequence 0,1,2,3,0 with grant_n 1110,1101,1011,0111,1110, one IDLE cycle between each.
REQ-028 req = 4'b0100 only, from reset -> grant after 1 cycle: sel = 2, grant_n = 4'b1011, enable = 0; release -> ptr = 3; then req = 4'b0101 -> sel = 0 (wrap).
REQ-029 In GRANT sel = 1, raise req[0] and req[3] without done -> sel, grant_n = 4'b1101 unchanged until req[1] drops, then IDLE next edge.
REQ-030 rst_n = 0 for one edge during GRANT sel = 2 -> next cycle enable = 1, grant_n = 4'b1111, sel = 0, busy = 0; req = 4'b1111 -> sel = 0.
REQ-031 RR_ARB_TIMEOUT_EN defined, MAX_HOLD = 4, req = 4'b0011 held, done = 0 -> sel = 0 for exactly 4 cycles, IDLE 1 cycle, then sel = 1; undefined -> sel = 0 held for 100+ cycles.
REQ-032 All runs: assert REQ-020 every cycle.
